// File: rtl/btn_debounce_if.sv
// Button conditioning bus: raw pins and CPU-side controls in, debounced state and events out.
// N_BTNS must match the btn_debounce instance it connects to.
interface btn_debounce_if #(
   parameter int N_BTNS = 5
);
   logic [N_BTNS-1:0] btns_raw;
   logic [N_BTNS-1:0] irq_mask;
   logic [N_BTNS-1:0] evt_clr;
   logic [N_BTNS-1:0] btns_level;
   logic [N_BTNS-1:0] btns_press;
   logic [N_BTNS-1:0] evt_pending;
   logic              irq;

   modport master (
      output btns_raw,
      output irq_mask,
      output evt_clr,
      input  btns_level,
      input  btns_press,
      input  evt_pending,
      input  irq
   );

   modport slave (
      input  btns_raw,
      input  irq_mask,
      input  evt_clr,
      output btns_level,
      output btns_press,
      output evt_pending,
      output irq
   );
endinterface

// File: rtl/btn_debounce.sv
// Per-channel two-flop synchroniser, stability timer and press-event logic
// feeding the CPU button register and its maskable interrupt.
module btn_debounce #(
   parameter int N_BTNS          = 5,
   parameter int DEBOUNCE_CYCLES = 1_000_000
) (
   input  logic            clk,
   input  logic            rst,
   btn_debounce_if.slave   bus
);
   localparam int             CNT_W    = $clog2(DEBOUNCE_CYCLES);
   localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(DEBOUNCE_CYCLES - 1);

   logic [N_BTNS-1:0] s1;
   logic [N_BTNS-1:0] s2;
   logic [N_BTNS-1:0] level_q;
   logic [N_BTNS-1:0] press_q;
   logic [N_BTNS-1:0] pend_q;
   logic [N_BTNS-1:0] accept;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         s1 <= '0;
         s2 <= '0;
      end else begin
         s1 <= bus.btns_raw;
         s2 <= s1;
      end
   end

   // Timer holds the number of further disagreeing samples still needed; a
   // full reload means nothing has been counted yet.
   for (genvar i = 0; i < N_BTNS; i++) begin : g_chan
      logic [CNT_W-1:0] cnt_q;

      always_ff @(posedge clk or negedge rst) begin
         if (!rst) begin
            cnt_q <= CNT_LOAD;
         end else if ((s2[i] == level_q[i]) || (cnt_q == '0)) begin
            cnt_q <= CNT_LOAD;
         end else begin
            cnt_q <= cnt_q - CNT_W'(1);
         end
      end

      assign accept[i] = (s2[i] != level_q[i]) && (cnt_q == '0);
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         level_q <= '0;
         press_q <= '0;
         pend_q  <= '0;
      end else begin
         level_q <= level_q ^ accept;
         press_q <= accept & ~level_q;
         // A press landing on a clear strobe still sets the flag.
         pend_q  <= (pend_q & ~bus.evt_clr) | press_q;
      end
   end

   assign bus.btns_level  = level_q;
   assign bus.btns_press  = press_q;
   assign bus.evt_pending = pend_q;
   assign bus.irq         = |(pend_q & bus.irq_mask);
endmodule

// File: tb/tb_btn_debounce.sv
// Bench for btn_debounce: cycle table plus hand sequences, checked through a scoreboard queue.
module tb_btn_debounce;
   localparam int N  = 5;
   localparam int DC = 4;

   logic clk = 1'b0;
   logic rst;

   btn_debounce_if #(.N_BTNS(N)) bus ();

   btn_debounce #(
      .N_BTNS          (N),
      .DEBOUNCE_CYCLES (DC)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic         rst;
      logic [N-1:0] raw;
      logic [N-1:0] mask;
      logic [N-1:0] clr;
      int           n;
      logic [N-1:0] lvl;
      logic [N-1:0] prs;
      logic [N-1:0] pnd;
      logic         irq;
      int           id;
   } vec_t;

   typedef struct {
      logic [N-1:0] lvl;
      logic [N-1:0] prs;
      logic [N-1:0] pnd;
      logic         irq;
      int           id;
   } exp_t;

   vec_t vecs[$];
   exp_t sb[$];
   int   checks   = 0;
   int   failures = 0;
   int   cyc      = 0;

   function automatic void add(input logic r, input logic [N-1:0] raw, mask, clr,
                               input int n, input logic [N-1:0] lvl, prs, pnd,
                               input logic irq, input int id);
      vec_t v;
      v.rst = r; v.raw = raw; v.mask = mask; v.clr = clr; v.n = n;
      v.lvl = lvl; v.prs = prs; v.pnd = pnd; v.irq = irq; v.id = id;
      vecs.push_back(v);
   endfunction

   task automatic chk(input string name, input int id, input logic [N-1:0] act, exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s test=%0d cycle=%0d actual=%b expected=%b", name, id, cyc, act, exp);
      end
   endtask

   // Drive one cycle of stimulus, queue its expectation, compare after the edge.
   task automatic step(input logic r, input logic [N-1:0] raw, mask, clr,
                       input logic [N-1:0] lvl, prs, pnd, input logic irq, input int id);
      exp_t e;
      exp_t got;
      @(negedge clk);
      rst            = r;
      bus.btns_raw   = raw;
      bus.irq_mask   = mask;
      bus.evt_clr    = clr;
      e.lvl = lvl; e.prs = prs; e.pnd = pnd; e.irq = irq; e.id = id;
      sb.push_back(e);
      @(posedge clk);
      #1;
      cyc++;
      got = sb.pop_front();
      chk("btns_level",  got.id, bus.btns_level,  got.lvl);
      chk("btns_press",  got.id, bus.btns_press,  got.prs);
      chk("evt_pending", got.id, bus.evt_pending, got.pnd);
      chk("irq",         got.id, N'(bus.irq),     N'(got.irq));
   endtask

   initial begin
      rst          = 1'b0;
      bus.btns_raw = 5'h1F;
      bus.irq_mask = 5'h1F;
      bus.evt_clr  = 5'h00;

      // 1: all buttons held through reset release
      add(0, 5'h1F, 5'h1F, 5'h00, 3, 5'h00, 5'h00, 5'h00, 0, 1);
      add(1, 5'h1F, 5'h1F, 5'h00, 5, 5'h00, 5'h00, 5'h00, 0, 1);
      add(1, 5'h1F, 5'h1F, 5'h00, 1, 5'h1F, 5'h1F, 5'h00, 0, 1);
      add(1, 5'h1F, 5'h1F, 5'h00, 1, 5'h1F, 5'h00, 5'h1F, 1, 1);
      add(1, 5'h00, 5'h1F, 5'h00, 5, 5'h1F, 5'h00, 5'h1F, 1, 1);
      add(1, 5'h00, 5'h1F, 5'h00, 1, 5'h00, 5'h00, 5'h1F, 1, 1);
      add(1, 5'h00, 5'h1F, 5'h1F, 1, 5'h00, 5'h00, 5'h00, 0, 1);
      add(1, 5'h00, 5'h1F, 5'h00, 1, 5'h00, 5'h00, 5'h00, 0, 1);
      // 2: clean press/release on bit 0
      add(1, 5'h01, 5'h1F, 5'h00, 5, 5'h00, 5'h00, 5'h00, 0, 2);
      add(1, 5'h01, 5'h1F, 5'h00, 1, 5'h01, 5'h01, 5'h00, 0, 2);
      add(1, 5'h01, 5'h1F, 5'h00, 4, 5'h01, 5'h00, 5'h01, 1, 2);
      add(1, 5'h00, 5'h1F, 5'h00, 5, 5'h01, 5'h00, 5'h01, 1, 2);
      add(1, 5'h00, 5'h1F, 5'h00, 1, 5'h00, 5'h00, 5'h01, 1, 2);
      add(1, 5'h00, 5'h1F, 5'h00, 2, 5'h00, 5'h00, 5'h01, 1, 2);
      // 3: bit 2 bouncing every 2 cycles
      for (int k = 0; k < 5; k++) begin
         add(1, 5'h04, 5'h1F, 5'h00, 2, 5'h00, 5'h00, 5'h01, 1, 3);
         add(1, 5'h00, 5'h1F, 5'h00, 2, 5'h00, 5'h00, 5'h01, 1, 3);
      end
      add(1, 5'h00, 5'h1F, 5'h00, 6, 5'h00, 5'h00, 5'h01, 1, 3);
      add(1, 5'h00, 5'h1F, 5'h01, 1, 5'h00, 5'h00, 5'h00, 0, 3);
      // 4: clear strobe colliding with the press pulse
      add(1, 5'h01, 5'h1F, 5'h00, 5, 5'h00, 5'h00, 5'h00, 0, 4);
      add(1, 5'h01, 5'h1F, 5'h00, 1, 5'h01, 5'h01, 5'h00, 0, 4);
      add(1, 5'h01, 5'h1F, 5'h01, 1, 5'h01, 5'h00, 5'h01, 1, 4);
      add(1, 5'h01, 5'h1F, 5'h01, 1, 5'h01, 5'h00, 5'h00, 0, 4);
      add(1, 5'h01, 5'h1F, 5'h00, 2, 5'h01, 5'h00, 5'h00, 0, 4);
      add(1, 5'h00, 5'h1F, 5'h00, 5, 5'h01, 5'h00, 5'h00, 0, 4);
      add(1, 5'h00, 5'h1F, 5'h00, 1, 5'h00, 5'h00, 5'h00, 0, 4);
      // 5: press on bit 3 with interrupts masked
      add(1, 5'h08, 5'h00, 5'h00, 5, 5'h00, 5'h00, 5'h00, 0, 5);
      add(1, 5'h08, 5'h00, 5'h00, 1, 5'h08, 5'h08, 5'h00, 0, 5);
      add(1, 5'h08, 5'h00, 5'h00, 1, 5'h08, 5'h00, 5'h08, 0, 5);

      for (int r = 0; r < vecs.size(); r++) begin
         for (int c = 0; c < vecs[r].n; c++) begin
            step(vecs[r].rst, vecs[r].raw, vecs[r].mask, vecs[r].clr,
                 vecs[r].lvl, vecs[r].prs, vecs[r].pnd, vecs[r].irq, vecs[r].id);
         end
      end

      // 5 continued: unmasking raises irq without waiting for an edge
      @(negedge clk);
      bus.irq_mask = 5'h08;
      #1;
      chk("irq_unmask_same_cycle", 5, N'(bus.irq), 5'h01);
      // clear on an already-clear bit leaves bit 3 alone
      step(1, 5'h08, 5'h08, 5'h01, 5'h08, 5'h00, 5'h08, 1, 5);
      step(1, 5'h00, 5'h08, 5'h08, 5'h08, 5'h00, 5'h00, 0, 5);
      for (int k = 0; k < 4; k++) step(1, 5'h00, 5'h08, 5'h00, 5'h08, 5'h00, 5'h00, 0, 5);
      step(1, 5'h00, 5'h08, 5'h00, 5'h00, 5'h00, 5'h00, 0, 5);

      // 6: reset in the middle of qualifying bit 1
      for (int k = 0; k < 3; k++) step(1, 5'h02, 5'h1F, 5'h00, 5'h00, 5'h00, 5'h00, 0, 6);
      for (int k = 0; k < 2; k++) step(0, 5'h02, 5'h1F, 5'h00, 5'h00, 5'h00, 5'h00, 0, 6);
      for (int k = 0; k < 5; k++) step(1, 5'h02, 5'h1F, 5'h00, 5'h00, 5'h00, 5'h00, 0, 6);
      step(1, 5'h02, 5'h1F, 5'h00, 5'h02, 5'h02, 5'h00, 0, 6);
      step(1, 5'h02, 5'h1F, 5'h00, 5'h02, 5'h00, 5'h02, 1, 6);

      // reset clears state without a clock edge
      @(negedge clk);
      rst = 1'b0;
      #1;
      chk("async_rst_level",   7, bus.btns_level,  5'h00);
      chk("async_rst_press",   7, bus.btns_press,  5'h00);
      chk("async_rst_pending", 7, bus.evt_pending, 5'h00);
      chk("async_rst_irq",     7, N'(bus.irq),     5'h00);
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
